// File: rtl/qspi_pkg.sv
// rtl/qspi_pkg.sv - shared states, opcodes and counter widths for the QSPI SRAM controller
package qspi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DATA_W,
    S_DUMMY,
    S_DATA_R,
    S_GAP
  } state_t;

  localparam logic [7:0] OP_WRITE  = 8'h38;
  localparam logic [7:0] OP_READ   = 8'hEB;

  localparam int CNT_W     = 5;
  localparam int CMD_BITS  = 8;
  localparam int ADDR_NIBS = 6;
  localparam int DATA_NIBS = 2;

  // States in which chip select is low and sck runs.
  function automatic logic is_active(input state_t s);
    return (s == S_CMD) || (s == S_ADDR) || (s == S_DATA_W) ||
           (s == S_DUMMY) || (s == S_DATA_R);
  endfunction

endpackage

// File: rtl/qspi_sram_ctrl.sv
// rtl/qspi_sram_ctrl.sv - byte-wide request port to 1S-4S-4S QSPI SRAM master, sck = clk/2
// QSPI_SRAM_CTRL_SEQ_EN enables sequential-address continuation without releasing ss_n.
module qspi_sram_ctrl
  import qspi_pkg::*;
#(
  parameter int         DUMMY_CYCLES = 4,
  parameter logic [7:0] CMD_WRITE    = OP_WRITE,
  parameter logic [7:0] CMD_READ     = OP_READ
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        sck,
  output logic        ss_n,
  output logic [3:0]  sio_out,
  output logic [3:0]  sio_oe,
  input  logic [3:0]  sio_in
);

  localparam logic [CNT_W-1:0] LAST_CMD   = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] LAST_ADDR  = CNT_W'(ADDR_NIBS - 1);
  localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(DATA_NIBS - 1);
  localparam logic [CNT_W-1:0] LAST_DUMMY = CNT_W'(DUMMY_CYCLES - 1);

  state_t           r_state, w_nxt_state;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt, w_cnt_inc;
  logic             r_sck, r_ss_n, r_write, r_rsp_valid;
  logic [23:0]      r_addr;
  logic [7:0]       r_wdata, r_rbuf, r_rdata;
  logic [3:0]       r_sio_out, r_sio_oe;
  logic             w_accept, w_done, w_fall, w_seq_hit, w_write_nxt;
  logic [7:0]       w_wdata_nxt, w_cmd;
  logic [3:0]       w_out, w_oe;

  assign w_fall    = r_sck;
  assign w_cnt_inc = r_cnt + 5'd1;

`ifdef QSPI_SRAM_CTRL_SEQ_EN
  assign w_seq_hit = req_valid && (req_write == r_write) && (req_addr == r_addr + 24'd1);
`else
  assign w_seq_hit = 1'b0;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_accept    = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept    = 1'b1;
          w_nxt_state = S_CMD;
          w_nxt_cnt   = '0;
        end
      end
      S_CMD: begin
        if (w_fall) begin
          if (r_cnt == LAST_CMD) begin
            w_nxt_state = S_ADDR;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = w_cnt_inc;
          end
        end
      end
      S_ADDR: begin
        if (w_fall) begin
          if (r_cnt == LAST_ADDR) begin
            w_nxt_cnt = '0;
            if (r_write)
              w_nxt_state = S_DATA_W;
            else if (DUMMY_CYCLES == 0)
              w_nxt_state = S_DATA_R;
            else
              w_nxt_state = S_DUMMY;
          end else begin
            w_nxt_cnt = w_cnt_inc;
          end
        end
      end
      S_DUMMY: begin
        if (w_fall) begin
          if (r_cnt == LAST_DUMMY) begin
            w_nxt_state = S_DATA_R;
            w_nxt_cnt   = '0;
          end else begin
            w_nxt_cnt = w_cnt_inc;
          end
        end
      end
      S_DATA_W, S_DATA_R: begin
        if (w_fall) begin
          if (r_cnt == LAST_DATA) begin
            w_done    = 1'b1;
            w_nxt_cnt = '0;
            // A matching follow-on request keeps ss_n low and relies on SRAM auto-increment.
            if (w_seq_hit)
              w_accept = 1'b1;
            else
              w_nxt_state = S_GAP;
          end else begin
            w_nxt_cnt = w_cnt_inc;
          end
        end
      end
      S_GAP: begin
        if (r_cnt == 5'd1) begin
          w_nxt_state = S_IDLE;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = w_cnt_inc;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  assign w_write_nxt = w_accept ? req_write : r_write;
  assign w_wdata_nxt = w_accept ? req_wdata : r_wdata;
  assign w_cmd       = w_write_nxt ? CMD_WRITE : CMD_READ;

  // Pad values are derived from the next state so they register on the sck falling edge.
  always_comb begin
    w_out = 4'b0000;
    w_oe  = 4'b0000;
    case (w_nxt_state)
      S_CMD: begin
        w_out = {3'b000, w_cmd[3'd7 - w_nxt_cnt[2:0]]};
        w_oe  = 4'b0001;
      end
      S_ADDR: begin
        w_oe = 4'b1111;
        case (w_nxt_cnt[2:0])
          3'd0:    w_out = r_addr[23:20];
          3'd1:    w_out = r_addr[19:16];
          3'd2:    w_out = r_addr[15:12];
          3'd3:    w_out = r_addr[11:8];
          3'd4:    w_out = r_addr[7:4];
          3'd5:    w_out = r_addr[3:0];
          default: w_out = 4'b0000;
        endcase
      end
      S_DATA_W: begin
        w_out = w_nxt_cnt[0] ? w_wdata_nxt[3:0] : w_wdata_nxt[7:4];
        w_oe  = 4'b1111;
      end
      default: begin
        w_out = 4'b0000;
        w_oe  = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_sck       <= 1'b0;
      r_ss_n      <= 1'b1;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rbuf      <= '0;
      r_rdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_sio_out   <= '0;
      r_sio_oe    <= '0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_sck       <= is_active(r_state) ? ~r_sck : 1'b0;
      r_ss_n      <= ~is_active(w_nxt_state);
      r_rsp_valid <= w_done;
      r_sio_out   <= w_out;
      r_sio_oe    <= w_oe;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == S_DATA_R && !r_sck)
        r_rbuf <= {r_rbuf[3:0], sio_in};
      if (w_done && !r_write)
        r_rdata <= r_rbuf;
    end
  end

  assign req_ready = (r_state == S_IDLE) | w_accept;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign sck       = r_sck;
  assign ss_n      = r_ss_n;
  assign sio_out   = r_sio_out;
  assign sio_oe    = r_sio_oe;

endmodule

// File: tb/tb_qspi_sram_ctrl.sv
// tb/tb_qspi_sram_ctrl.sv - directed bench for qspi_sram_ctrl with a behavioural QSPI SRAM model
`timescale 1ns/1ps
module tb_qspi_sram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [23:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_ready, rsp_valid, sck, ss_n;
  logic [7:0]  rsp_rdata;
  logic [3:0]  sio_out, sio_oe;
  logic [3:0]  sio_in = 4'h0;

  always #5 clk = ~clk;

  qspi_sram_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sck(sck), .ss_n(ss_n), .sio_out(sio_out), .sio_oe(sio_oe), .sio_in(sio_in)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // SRAM model: samples on sck rise, drives read nibbles after sck fall.
  logic [7:0]  mem [bit [23:0]];
  int          m_e = 0;
  int          m_last_e = 0;
  int          m_wcnt = 0;
  logic [7:0]  m_cmd = '0;
  logic [23:0] m_addr = '0;
  logic [3:0]  m_hi = '0;
  logic [23:0] m_waddr = '0;
  logic [7:0]  m_wdata = '0;

  always @(posedge sck or posedge ss_n) begin
    int k;
    if (ss_n) begin
      if (m_e != 0) m_last_e = m_e;
      m_e = 0;
    end else begin
      if (m_e < 8) m_cmd = {m_cmd[6:0], sio_out[0]};
      else if (m_e < 14) m_addr = {m_addr[19:0], sio_out};
      else if (m_cmd == 8'h38) begin
        k = m_e - 14;
        if (k % 2 == 0) m_hi = sio_out;
        else begin
          m_waddr = m_addr + 24'(k / 2);
          m_wdata = {m_hi, sio_out};
          mem[m_waddr] = m_wdata;
          m_wcnt++;
        end
      end
      m_e++;
    end
  end

  always @(negedge sck) begin
    int k;
    logic [7:0] b;
    if (!ss_n && m_cmd == 8'hEB && m_e >= 18) begin
      k = m_e - 18;
      b = mem[m_addr + 24'(k / 2)];
      sio_in = (k % 2 == 1) ? b[3:0] : b[7:4];
    end
  end

  // Bus monitor, sampled mid-cycle.
  int cyc = 0, rsp_cnt = 0, acc_cnt = 0, fall_cnt = 0, hi_run = 0, min_hi = 999, oe_bad = 0;
  logic prev_ss_n = 1'b1;
  int   rsp_cyc[$];
  logic [7:0] rsp_dat[$];

  always @(negedge clk) begin
    cyc++;
    if (rsp_valid) begin
      rsp_cnt++;
      rsp_cyc.push_back(cyc);
      rsp_dat.push_back(rsp_rdata);
    end
    if (req_valid && req_ready) acc_cnt++;
    if (ss_n) hi_run++;
    else begin
      if (prev_ss_n) begin
        fall_cnt++;
        if (hi_run < min_hi) min_hi = hi_run;
      end
      hi_run = 0;
    end
    prev_ss_n = ss_n;
    if (!ss_n && m_cmd == 8'hEB && (m_e > 14 || (m_e == 14 && !sck)) && sio_oe != 4'h0)
      oe_bad++;
  end

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (req_ready) return;
    end
    chk("idle_timeout", 0, 1);
  endtask

  task automatic do_req(input logic w, input logic [23:0] a, input logic [7:0] d, output int lat);
    bit seen;
    wait_idle();
    req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (req_ready) seen = 1;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) seen = 1;
      else lat++;
    end
    if (!seen) lat = -1;
  endtask

  int lat, r0, f0, a0, w0, n;

  initial begin
    mem[24'h012345] = 8'h00;
    mem[24'hFFFFFF] = 8'h5A;
    mem[24'h000010] = 8'h00;
    mem[24'h000100] = 8'h11;
    mem[24'h000101] = 8'h22;
    mem[24'h000102] = 8'h33;

    #1 rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst_ss_n", ss_n, 1);
    chk("rst_sck", sck, 0);
    chk("rst_sio_out", sio_out, 0);
    chk("rst_sio_oe", sio_oe, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    do_req(1'b1, 24'h012345, 8'hA5, lat);
    chk("wr_latency", lat, 32);
    chk("wr_cmd", m_cmd, 8'h38);
    chk("wr_sck_count", m_last_e, 16);
    chk("wr_log_addr", m_waddr, 24'h012345);
    chk("wr_log_data", m_wdata, 8'hA5);

    oe_bad = 0;
    do_req(1'b0, 24'h012345, 8'h00, lat);
    chk("rd_latency", lat, 40);
    chk("rd_data", rsp_rdata, 8'hA5);
    chk("rd_cmd", m_cmd, 8'hEB);
    chk("rd_sck_count", m_last_e, 20);
    chk("rd_oe_turnaround", oe_bad, 0);

    do_req(1'b1, 24'hFFFFFF, 8'h00, lat);
    chk("wr_ff_addr_nibbles", m_addr, 24'hFFFFFF);
    chk("wr_ff_mem", mem[24'hFFFFFF], 8'h00);
    do_req(1'b0, 24'hFFFFFF, 8'h00, lat);
    chk("rd_ff_data", rsp_rdata, 8'h00);
    chk("rd_ff_latency", lat, 40);

    // Reset during the third address nibble.
    wait_idle();
    req_write = 1'b1; req_addr = 24'h000010; req_wdata = 8'h3C; req_valid = 1'b1;
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (21) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_oe", sio_oe, 4'hF);
    r0 = rsp_cnt; w0 = m_wcnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_ss_n", ss_n, 1);
    chk("midrst_sio_oe", sio_oe, 0);
    chk("midrst_req_ready", req_ready, 1);
    chk("midrst_sck", sck, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(posedge clk);
    chk("midrst_no_rsp", rsp_cnt - r0, 0);
    chk("midrst_no_write", m_wcnt - w0, 0);
    do_req(1'b1, 24'h000010, 8'h3C, lat);
    chk("post_rst_wr_lat", lat, 32);
    chk("post_rst_mem", mem[24'h000010], 8'h3C);

    // req_valid held high across several transactions.
    wait_idle();
    min_hi = 999; f0 = fall_cnt; a0 = acc_cnt; r0 = rsp_cnt;
    req_write = 1'b1; req_addr = 24'h000020; req_wdata = 8'h77; req_valid = 1'b1;
    repeat (80) @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (60) @(posedge clk);
    chk("held_accepts", acc_cnt - a0, 3);
    chk("held_ss_falls", fall_cnt - f0, 3);
    chk("held_rsps", rsp_cnt - r0, 3);
    chk("held_min_ss_high", (min_hi >= 2) ? 1 : 0, 1);

    // Back-to-back reads of consecutive addresses.
    wait_idle();
    f0 = fall_cnt; r0 = rsp_cnt; n = 0;
    req_write = 1'b0; req_addr = 24'h000100; req_valid = 1'b1;
    for (int i = 0; i < 400 && n < 3; i++) begin
      @(negedge clk);
      if (req_ready) begin
        n++;
        @(posedge clk); #1;
        if (n == 3) req_valid = 1'b0;
        else req_addr = 24'h000100 + 24'(n);
      end
    end
    req_valid = 1'b0;
    chk("seq_accepts", n, 3);
    repeat (100) @(posedge clk);
    chk("seq_rsps", rsp_cnt - r0, 3);
    if (rsp_cnt - r0 == 3) begin
      chk("seq_data0", rsp_dat[r0], 8'h11);
      chk("seq_data1", rsp_dat[r0 + 1], 8'h22);
      chk("seq_data2", rsp_dat[r0 + 2], 8'h33);
`ifdef QSPI_SRAM_CTRL_SEQ_EN
      chk("seq_gap01", rsp_cyc[r0 + 1] - rsp_cyc[r0], 4);
      chk("seq_gap12", rsp_cyc[r0 + 2] - rsp_cyc[r0 + 1], 4);
`endif
    end
`ifdef QSPI_SRAM_CTRL_SEQ_EN
    chk("seq_one_cmd_phase", fall_cnt - f0, 1);
    chk("seq_sck_count", m_last_e, 24);
`else
    chk("seq_separate_txn", fall_cnt - f0, 3);
    chk("seq_sck_count", m_last_e, 20);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/qspi_sram_ctrl.md
# qspi_sram_ctrl

- Single-port master that turns byte-wide read/write requests from the core into QSPI SRAM transactions.
- Uses command 0x38 (1S-4S-4S write) and command 0xEB (1S-4S-4S read with dummy cycles).
- Sits between the core's memory-request port and the chip's QSPI pads.
- Generates `sck` at clk/2 and owns `ss_n`, pad output-enables and read sampling.

## Interface
- `DUMMY_CYCLES`, default 4: number of sck cycles between the last address nibble and the first read nibble.
- `CMD_WRITE`, default 8'h38: quad write opcode.
- `CMD_READ`, default 8'hEB: quad read opcode.
- `clk  in  1`: system clock. All logic is on the rising edge.
- `rst_n  in  1`: reset, asynchronous and active-low.
- `req_valid  in  1`: request present.
- `req_ready  out  1`: controller accepts a request this cycle.
- `req_write  in  1`: 1 = write, 0 = read.
- `req_addr  in  24`: byte address.
- `req_wdata  in  8`: write data.
- `rsp_valid  out  1`: one-cycle pulse. On a read it carries `rsp_rdata`; on a write it marks completion.
- `rsp_rdata  out  8`: read data. Holds its value until the next read response.
- `sck  out  1`: SPI clock.
- `ss_n  out  1`: chip select, active-low.
- `sio_out  out  4`: pad output data.
- `sio_oe  out  4`: pad output-enable, one bit per line.
- `sio_in  in  4`: pad input data.

## Operation
- **Handshake:**
  - `req_ready` = 1 only in IDLE. A request transfers when `req_valid && req_ready`.
  - `req_write`, `req_addr` and `req_wdata` are latched on the transfer.
- **sck and driving:**
  - `sck` toggles every clk while `ss_n` = 0 and idles low.
  - Outputs change only on clk edges where `sck` goes 1->0, or when `ss_n` asserts.
  - The SRAM samples on the sck rising edge.
- **States:** IDLE -> CMD -> ADDR -> (write) DATA_W / (read) DUMMY -> DATA_R -> GAP -> IDLE.
- **CMD:**
  - 8 sck cycles, MSB first, on `sio_out[0]`.
  - `sio_oe` = 4'b0001; the other `sio_out` bits are 0.
- **ADDR:**
  - 6 sck cycles, one nibble each, bits [23:20] first.
  - `sio_oe` = 4'b1111.
- **DATA_W:**
  - 2 sck cycles: `wdata[7:4]`, then `wdata[3:0]`.
  - `sio_oe` = 4'b1111.
- **DUMMY:**
  - `DUMMY_CYCLES` sck cycles with `sio_oe` = 0 (bus turnaround).
- **DATA_R:**
  - 2 sck cycles with `sio_oe` = 0.
  - `sio_in` is sampled on the clk edge where `sck` goes 0->1: high nibble first, then low nibble.
- **GAP:**
  - `ss_n` = 1 for 2 clk.
  - `rsp_valid` pulses on the first GAP clk.
  - `sio_oe` = 0.
- **Counters:** one 5-bit bit/nibble counter and one phase bit (the `sck` register); wrap is not needed.
- **Reset mid-transaction:** immediately forces `ss_n` = 1, `sck` = 0 and `sio_oe` = 0, returns to IDLE and drops the request with no response. The SRAM resets its own state on `ss_n` high.

## Timing
- **Reset values:**
  - `ss_n` = 1, `sck` = 0, `sio_out` = 0, `sio_oe` = 0.
  - `req_ready` = 1, `rsp_valid` = 0, `rsp_rdata` = 0.
- **Write:** `ss_n` falls on the clk after acceptance. 16 sck = 32 clk, then `rsp_valid`.
- **Read:**
  - (8+6+`DUMMY_CYCLES`+2) sck; with the default, 20 sck = 40 clk.
  - `rsp_valid` follows on the next clk.
- **Throughput:** `req_ready` returns 2 clk after `rsp_valid`. The minimum `ss_n` high time is 2 clk.
- **Stalled request:** `req_valid` asserted while not ready has no effect. The requester holds it.
- **Concurrent events:** none. There is a single requester, and `rsp_valid` and `req_ready` are never both 1.

## Configuration
- **Macro:** `QSPI_SRAM_CTRL_SEQ_EN`.
- **Defined (sequential continuation):**
  - In DATA_W/DATA_R, at the end of the byte, the controller checks for a pending `req_valid` of the same type with `req_addr` == last address + 1.
  - If present, it accepts it (`req_ready` pulses for that cycle) and stays in DATA_x for the next byte with `ss_n` held low. The SRAM's address auto-increment is relied on.
  - `rsp_valid` pulses per byte, in the clk after each byte's last nibble.
  - Any non-matching request, or no request, goes to GAP.
- **Undefined:** every byte is a full transaction.

## Structure
- **Package `qspi_pkg`:**
  - state enum: IDLE, CMD, ADDR, DATA_W, DUMMY, DATA_R, GAP.
  - opcode constants 8'h38 and 8'hEB.
  - nibble/command counter widths.
- **Sub-module:** no separate sub-module. The shifter is inlined, because shift timing is tied to the FSM phase.

## Test plan
- **Write 0xA5 to 0x012345 against the SRAM model:**
  - model logs `W [012345] <= A5`.
  - `rsp_valid` 32 clk after `ss_n` falls.
  - 8 sck before 0x38 is complete.
- **Read back 0x012345:**
  - `rsp_rdata` = 0xA5 after 40 clk.
  - `sio_oe` = 0 throughout DUMMY and DATA_R.
- **Write 0x00 to 0xFFFFFF, then read it:**
  - returns 0x00.
  - address nibbles observed as F,F,F,F,F,F.
- **Reset asserted during ADDR (3rd nibble):**
  - `ss_n` = 1, `sio_oe` = 0 and `req_ready` = 1 in the same cycle.
  - no `rsp_valid`.
  - next write then succeeds.
- **`req_valid` held during a transfer:**
  - exactly one acceptance per transaction.
  - `ss_n` stays high for ≥2 clk between transactions.
- **With `QSPI_SRAM_CTRL_SEQ_EN`, reads of 0x100, 0x101, 0x102 back-to-back:**
  - one CMD/ADDR phase only.
  - three `rsp_valid` pulses, 4 clk apart.
  - data matches the preloaded bytes.
